// File: rtl/noc_output_port.sv
// noc_output_port: one output port of a 5-input NoC router.
// Arbitrates round-robin among packet heads from N/S/E/W/L input buffers,
// holds a wormhole lock on the winner until its tail flit, and meters flits
// against a downstream credit counter.
// Ports:
//   clk, rst                      clock, async active-low reset
//   {north,south,east,west,local}_q_i  head flit of each input buffer
//   en_{n,s,e,w,l}_i              input buffer head valid
//   req_{n,s,e,w,l}_i             route computation targets this output
//   pop_req_{n,s,e,w,l}_o         pop that input's head this edge (same-cycle)
//   credit_i                      downstream freed one slot (pulse)
//   data_o, valid_o               registered outgoing flit
module noc_output_port #(
   parameter int unsigned CREDITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] north_q_i,
   input  logic [15:0] south_q_i,
   input  logic [15:0] east_q_i,
   input  logic [15:0] west_q_i,
   input  logic [15:0] local_q_i,
   input  logic        en_n_i,
   input  logic        en_s_i,
   input  logic        en_e_i,
   input  logic        en_w_i,
   input  logic        en_l_i,
   input  logic        req_n_i,
   input  logic        req_s_i,
   input  logic        req_e_i,
   input  logic        req_w_i,
   input  logic        req_l_i,
   output logic        pop_req_n_o,
   output logic        pop_req_s_o,
   output logic        pop_req_e_o,
   output logic        pop_req_w_o,
   output logic        pop_req_l_o,
   input  logic        credit_i,
   output logic [15:0] data_o,
   output logic        valid_o
);

   localparam int unsigned CW  = $clog2(CREDITS + 1);
   localparam int unsigned NIN = 5;
   localparam int unsigned FW  = 16;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   state_e          state_q;
   logic [2:0]      lock_q;
   logic [2:0]      rr_q;
   logic [CW-1:0]   cred_q;
   logic [CW-1:0]   cred_d;
   logic [FW-1:0]   data_q;
   logic            valid_q;

   logic [FW-1:0]   flit [NIN];
   logic [NIN-1:0]  en_v;
   logic [NIN-1:0]  req_v;
   logic [NIN-1:0]  elig;
   logic [NIN-1:0]  pop_v;
   logic [2:0]      cand;
   logic [2:0]      win;
   logic            found;
   logic [2:0]      sel;
   logic            do_pop;
   logic            can_send;
   logic [FW-1:0]   sel_flit;

   // Gather inputs into indexable form: n=0, s=1, e=2, w=3, l=4.
   always_comb begin
      flit[0] = north_q_i;
      flit[1] = south_q_i;
      flit[2] = east_q_i;
      flit[3] = west_q_i;
      flit[4] = local_q_i;
      en_v    = {en_l_i, en_w_i, en_e_i, en_s_i, en_n_i};
      req_v   = {req_l_i, req_w_i, req_e_i, req_s_i, req_n_i};
   end

   // Only packet-opening flits (head 10, single 11: bit 15 set) may win in IDLE.
   always_comb begin
      for (int unsigned i = 0; i < NIN; i++) begin
         elig[i] = req_v[i] & en_v[i] & flit[i][15];
      end
   end

   // Round-robin scan starting just after the last winner.
   always_comb begin
      win   = 3'd0;
      found = 1'b0;
      cand  = 3'd0;
      for (int unsigned k = 1; k <= NIN; k++) begin
         cand = 3'((32'(rr_q) + 32'(k)) % 32'(NIN));
         if (!found && elig[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Pop selection; rst gating keeps pops low while reset is asserted.
   always_comb begin
      can_send = (cred_q != '0);
      sel      = win;
      do_pop   = 1'b0;
      if (state_q == IDLE) begin
         do_pop = found & can_send;
      end else begin
         sel    = lock_q;
         do_pop = en_v[lock_q] & can_send;
      end
      if (!rst) do_pop = 1'b0;
      for (int unsigned i = 0; i < NIN; i++) begin
         pop_v[i] = do_pop && (sel == 3'(i));
      end
      sel_flit = flit[sel];
   end

   // Credit counter: a pop and a returned credit on the same edge cancel.
   always_comb begin
      cred_d = cred_q;
      unique case ({do_pop, credit_i})
         2'b10:   cred_d = cred_q - CW'(1);
         2'b01:   cred_d = (cred_q == CW'(CREDITS)) ? cred_q : cred_q + CW'(1);
         default: cred_d = cred_q;
      endcase
   end

   // Lock FSM, round-robin pointer and output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         lock_q  <= 3'd0;
         rr_q    <= 3'd4;
         cred_q  <= CW'(CREDITS);
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cred_q  <= cred_d;
         valid_q <= do_pop;
         if (do_pop) begin
            data_q <= sel_flit;
            if (state_q == IDLE) begin
               rr_q <= sel;
               // A head (bit 14 clear) opens a packet; a single flit does not.
               if (!sel_flit[14]) begin
                  state_q <= LOCKED;
                  lock_q  <= sel;
               end
            end else if (sel_flit[14]) begin
               state_q <= IDLE;
            end
         end
      end
   end

   assign pop_req_n_o = pop_v[0];
   assign pop_req_s_o = pop_v[1];
   assign pop_req_e_o = pop_v[2];
   assign pop_req_w_o = pop_v[3];
   assign pop_req_l_o = pop_v[4];
   assign data_o      = data_q;
   assign valid_o     = valid_q;

endmodule

// File: tb/tb_noc_output_port.sv
// Bench for noc_output_port: directed vector table, a hand-written async
// reset sequence, and randomized traffic against a packet-level model.
module tb_noc_output_port;

   localparam int unsigned CREDITS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] q [5];
   logic [4:0]  en;
   logic [4:0]  req;
   logic        credit;
   logic        pop_n, pop_s, pop_e, pop_w, pop_l;
   logic [15:0] data_o;
   logic        valid_o;
   logic [4:0]  pop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign pop = {pop_l, pop_w, pop_e, pop_s, pop_n};

   noc_output_port #(.CREDITS(CREDITS)) dut (
      .clk(clk), .rst(rst),
      .north_q_i(q[0]), .south_q_i(q[1]), .east_q_i(q[2]), .west_q_i(q[3]), .local_q_i(q[4]),
      .en_n_i(en[0]), .en_s_i(en[1]), .en_e_i(en[2]), .en_w_i(en[3]), .en_l_i(en[4]),
      .req_n_i(req[0]), .req_s_i(req[1]), .req_e_i(req[2]), .req_w_i(req[3]), .req_l_i(req[4]),
      .pop_req_n_o(pop_n), .pop_req_s_o(pop_s), .pop_req_e_o(pop_e),
      .pop_req_w_o(pop_w), .pop_req_l_o(pop_l),
      .credit_i(credit), .data_o(data_o), .valid_o(valid_o)
   );

   // ---------------- reference model (packet-level) ----------------
   int          m_rr;
   int          m_lock;
   bit          m_locked;
   int          m_cred;
   logic [15:0] m_data;
   bit          m_valid;

   function automatic void model_reset();
      m_rr = 4; m_lock = 0; m_locked = 0; m_cred = CREDITS;
      m_data = 16'h0; m_valid = 0;
   endfunction

   // Which input is popped this cycle (-1 for none).
   function automatic int model_pop();
      if (m_cred == 0) return -1;
      if (m_locked) return en[m_lock] ? m_lock : -1;
      for (int k = 1; k <= 5; k++) begin
         int idx;
         idx = (m_rr + k) % 5;
         if (req[idx] && en[idx] && q[idx][15]) return idx;
      end
      return -1;
   endfunction

   function automatic void model_edge(int p);
      logic [15:0] f;
      if (p >= 0) begin
         f = q[p];
         m_data = f; m_valid = 1;
         if (!m_locked) begin
            m_rr = p;
            if (f[15:14] == 2'b10) begin m_locked = 1; m_lock = p; end
         end else if (f[15:14] == 2'b01) begin
            m_locked = 0;
         end
      end else begin
         m_valid = 0;
      end
      m_cred = m_cred - ((p >= 0) ? 1 : 0) + (credit ? 1 : 0);
      if (m_cred > CREDITS) m_cred = CREDITS;
   endfunction

   function automatic logic [4:0] mask(int p);
      return (p < 0) ? 5'd0 : 5'(1 << p);
   endfunction

   // ---------------- helpers ----------------
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge.
   task automatic run_cycle(output logic [4:0] p_act, output logic v_act,
                            output logic [15:0] d_act, output int mp);
      #1;
      p_act = pop;
      mp = model_pop();
      @(posedge clk);
      model_edge(mp);
      #1;
      v_act = valid_o;
      d_act = data_o;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      credit = 1'b0;
      for (int i = 0; i < 5; i++) q[i] = 16'h0;
      q[0] = 16'hC0FF; req = 5'b00001; en = 5'b00001;
      @(negedge clk);
      @(negedge clk);
      check("rst pop", 32'(pop), 32'd0);
      check("rst valid", 32'(valid_o), 32'd0);
      check("rst data", 32'(data_o), 32'd0);
      req = 5'd0; en = 5'd0; q[0] = 16'h0;
      rst = 1'b1;
      model_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          rst_before;
      logic [4:0]  req;
      logic [4:0]  en;
      logic [15:0] qn, qs, qe, qw, ql;
      bit          cr;
      logic [4:0]  exp_pop;
      bit          exp_valid;
      logic [15:0] exp_data;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, logic [4:0] rq, logic [4:0] e,
                               logic [15:0] qn, logic [15:0] qs, logic [15:0] qe,
                               logic [15:0] qw, logic [15:0] ql, bit cr,
                               logic [4:0] ep, bit ev, logic [15:0] ed);
      vec_t v;
      v.rst_before = r; v.req = rq; v.en = e;
      v.qn = qn; v.qs = qs; v.qe = qe; v.qw = qw; v.ql = ql;
      v.cr = cr; v.exp_pop = ep; v.exp_valid = ev; v.exp_data = ed;
      return v;
   endfunction

   initial begin
      logic [4:0]  pa;
      logic        va;
      logic [15:0] da;
      int          mp;
      int          ty;

      rst = 1'b0; req = 5'd0; en = 5'd0; credit = 1'b0;
      for (int i = 0; i < 5; i++) q[i] = 16'h0;

      // Single flit from north right after reset.
      tbl.push_back(mk(1, 5'b00001, 5'b00001, 16'hC00A, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hC00A));
      tbl.push_back(mk(0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 16'h0));
      // South and west singles alternate starting with south.
      tbl.push_back(mk(1, 5'b01010, 5'b01010, 0, 16'hC011, 0, 16'hC033, 0, 1, 5'b00010, 1, 16'hC011));
      tbl.push_back(mk(0, 5'b01010, 5'b01010, 0, 16'hC011, 0, 16'hC033, 0, 1, 5'b01000, 1, 16'hC033));
      tbl.push_back(mk(0, 5'b01010, 5'b01010, 0, 16'hC011, 0, 16'hC033, 0, 1, 5'b00010, 1, 16'hC011));
      tbl.push_back(mk(0, 5'b01010, 5'b01010, 0, 16'hC011, 0, 16'hC033, 0, 1, 5'b01000, 1, 16'hC033));
      // East packet stays contiguous while north waits.
      tbl.push_back(mk(1, 5'b00100, 5'b00100, 0, 0, 16'h8001, 0, 0, 0, 5'b00100, 1, 16'h8001));
      tbl.push_back(mk(0, 5'b00101, 5'b00101, 16'hC00A, 0, 16'h0002, 0, 0, 1, 5'b00100, 1, 16'h0002));
      tbl.push_back(mk(0, 5'b00101, 5'b00101, 16'hC00A, 0, 16'h4003, 0, 0, 1, 5'b00100, 1, 16'h4003));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hC00A, 0, 0, 0, 0, 1, 5'b00001, 1, 16'hC00A));
      // Local packet runs out of credits; one credit releases one flit; req ignored while locked.
      tbl.push_back(mk(1, 5'b10000, 5'b10000, 0, 0, 0, 0, 16'h8100, 0, 5'b10000, 1, 16'h8100));
      tbl.push_back(mk(0, 5'b00000, 5'b10000, 0, 0, 0, 0, 16'h0101, 0, 5'b10000, 1, 16'h0101));
      tbl.push_back(mk(0, 5'b00000, 5'b10000, 0, 0, 0, 0, 16'h0102, 0, 5'b10000, 1, 16'h0102));
      tbl.push_back(mk(0, 5'b00000, 5'b10000, 0, 0, 0, 0, 16'h0103, 0, 5'b10000, 1, 16'h0103));
      tbl.push_back(mk(0, 5'b10000, 5'b10000, 0, 0, 0, 0, 16'h0104, 0, 5'b00000, 0, 16'h0));
      tbl.push_back(mk(0, 5'b10000, 5'b10000, 0, 0, 0, 0, 16'h0104, 1, 5'b00000, 0, 16'h0));
      tbl.push_back(mk(0, 5'b00000, 5'b10000, 0, 0, 0, 0, 16'h0104, 0, 5'b10000, 1, 16'h0104));
      tbl.push_back(mk(0, 5'b10000, 5'b10000, 0, 0, 0, 0, 16'h0105, 0, 5'b00000, 0, 16'h0));
      // Pop and credit together at count 2 leaves 2.
      tbl.push_back(mk(1, 5'b00001, 5'b00001, 16'hC001, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hC001));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hC002, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hC002));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hC003, 0, 0, 0, 0, 1, 5'b00001, 1, 16'hC003));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hC004, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hC004));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hC005, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hC005));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hC006, 0, 0, 0, 0, 0, 5'b00000, 0, 16'h0));
      // Credit at full count saturates.
      tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 16'h0));
      tbl.push_back(mk(0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 16'h0));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hD001, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hD001));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hD002, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hD002));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hD003, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hD003));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hD004, 0, 0, 0, 0, 0, 5'b00001, 1, 16'hD004));
      tbl.push_back(mk(0, 5'b00001, 5'b00001, 16'hD005, 0, 0, 0, 0, 0, 5'b00000, 0, 16'h0));
      // Body/tail at a requesting input is not popped in IDLE.
      tbl.push_back(mk(1, 5'b00011, 5'b00011, 16'h0005, 16'h4006, 0, 0, 0, 0, 5'b00000, 0, 16'h0));
      tbl.push_back(mk(0, 5'b00011, 5'b00011, 16'h0005, 16'hC007, 0, 0, 0, 0, 5'b00010, 1, 16'hC007));

      foreach (tbl[i]) begin
         if (tbl[i].rst_before) do_reset();
         req = tbl[i].req; en = tbl[i].en; credit = tbl[i].cr;
         q[0] = tbl[i].qn; q[1] = tbl[i].qs; q[2] = tbl[i].qe;
         q[3] = tbl[i].qw; q[4] = tbl[i].ql;
         run_cycle(pa, va, da, mp);
         check($sformatf("tbl%0d pop", i), 32'(pa), 32'(tbl[i].exp_pop));
         check($sformatf("tbl%0d valid", i), 32'(va), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) check($sformatf("tbl%0d data", i), 32'(da), 32'(tbl[i].exp_data));
      end

      // Asynchronous reset while locked on west.
      do_reset();
      credit = 1'b0;
      req = 5'b01000; en = 5'b01000; q[3] = 16'h8300;
      run_cycle(pa, va, da, mp);
      check("lockw head pop", 32'(pa), 32'(5'b01000));
      q[3] = 16'h0301;
      run_cycle(pa, va, da, mp);
      check("lockw body pop", 32'(pa), 32'(5'b01000));
      check("lockw body data", 32'(da), 32'h0301);
      q[3] = 16'h0302;
      #2 rst = 1'b0;
      #1;
      check("async pop", 32'(pop), 32'd0);
      check("async valid", 32'(valid_o), 32'd0);
      check("async data", 32'(data_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      q[3] = 16'h0303;
      run_cycle(pa, va, da, mp);
      check("postrst body pop", 32'(pa), 32'd0);
      check("postrst valid", 32'(va), 32'd0);
      // Full credit count restored: exactly four singles go out.
      for (int i = 0; i < 5; i++) begin
         req = 5'b01001; en = 5'b01001; q[0] = 16'hC100 + 16'(i);
         run_cycle(pa, va, da, mp);
         check($sformatf("postrst n%0d pop", i), 32'(pa), (i < 4) ? 32'd1 : 32'd0);
      end

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         credit = ($urandom_range(2) == 0);
         for (int i = 0; i < 5; i++) begin
            en[i]  = ($urandom_range(3) != 0);
            req[i] = $urandom_range(1);
            ty = $urandom_range(3);
            if (m_locked && i == m_lock) ty = $urandom_range(1);
            q[i] = {2'(ty), 14'($urandom)};
         end
         run_cycle(pa, va, da, mp);
         check($sformatf("rnd%0d pop", c), 32'(pa), 32'(mask(mp)));
         check($sformatf("rnd%0d valid", c), 32'(va), 32'(m_valid));
         check($sformatf("rnd%0d data", c), 32'(da), 32'(m_data));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_output_port.md
NOC_OUTPUT_PORT -- requirements
Module: noc_output_port

Interface
REQ-001 SHALL have parameter CREDITS, default 4; downstream input-buffer depth in flits, range 1..7.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports north_q_i, south_q_i, east_q_i, west_q_i, local_q_i  in  16 each  head flit of each input buffer.
REQ-005 SHALL have ports en_n_i, en_s_i, en_e_i, en_w_i, en_l_i  in  1 each  input buffer non-empty, head flit valid.
REQ-006 SHALL have ports req_n_i, req_s_i, req_e_i, req_w_i, req_l_i  in  1 each  route computation: that input's head flit targets this output.
REQ-007 SHALL have ports pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o  out  1 each  pop the head of that input buffer at this clock edge.
REQ-008 SHALL have port credit_i  in  1  one-cycle pulse; downstream freed one flit slot.
REQ-009 SHALL have port data_o  out  16  outgoing flit, registered.
REQ-010 SHALL have port valid_o  out  1  data_o valid this cycle, registered.

Function
REQ-011 SHALL decode flit type from bits [15:14]: 10 head, 00 body, 01 tail, 11 single (head+tail).
REQ-012 SHALL index inputs n=0, s=1, e=2, w=3, l=4 for arbitration.
REQ-013 SHALL keep a credit counter of width $clog2(CREDITS+1); send requires count>0.
REQ-014 SHALL keep FSM states IDLE and LOCKED, plus a 3-bit lock index and a 3-bit round-robin pointer rr (last winner).
REQ-015 IDLE: eligible input x = req_x & en_x & flit type head or single; winner = first eligible scanning rr+1, rr+2, ... modulo 5.
REQ-016 IDLE with eligible input and credit>0: SHALL assert pop_req of the winner combinationally in the same cycle; rr <= winner.
REQ-017 IDLE grant of a head flit: SHALL go LOCKED with lock=winner; grant of a single flit: SHALL stay IDLE.
REQ-018 IDLE: body or tail flit at a requesting input SHALL NOT be popped or granted; it waits.
REQ-019 LOCKED: SHALL assert pop_req of lock input only, when en_lock & credit>0; req_* inputs ignored.
REQ-020 LOCKED: popping a tail flit SHALL return to IDLE; a body flit keeps LOCKED.
REQ-021 At most one pop_req_*_o SHALL be high in any cycle; none when credit=0.
REQ-022 On a pop edge: data_o <= popped head flit, valid_o <= 1; otherwise valid_o <= 0 and data_o holds its value; latency pop -> valid_o = 1 cycle.
REQ-023 Credit update per edge: pop only -> count-1; credit_i only -> count+1; both -> unchanged; neither -> unchanged.
REQ-024 credit_i while count=CREDITS and no pop SHALL saturate at CREDITS.
REQ-025 Sustained throughput SHALL be one flit per cycle while credits and flits are available.

Reset
REQ-026 rst low SHALL immediately force: state IDLE, lock 0, rr 4 (north has first priority), credit count CREDITS, data_o 0, valid_o 0, all pop_req_*_o 0.
REQ-027 Reset asserted mid-packet SHALL abandon the lock; after release the block arbitrates afresh from IDLE.

Verification
REQ-028 After reset, req_n_i=1, en_n_i=1, north_q_i=16'hC00A (single) -> pop_req_n_o=1 same cycle, next cycle valid_o=1, data_o=16'hC00A, credit=3, state IDLE.
REQ-029 req_s, req_w both high with single flits, rr=4 -> south granted first, west next cycle; with req held, grants alternate s, w, s, w.
REQ-030 East sends head 8001, body 0002, tail 4003 while north requests with a single flit -> east flits appear on data_o contiguously, north granted only after the tail.
REQ-031 CREDITS=4, no credit_i, 6 body flits locked from local -> exactly 4 pops, then pop_req low; one credit_i pulse -> exactly one more pop.
REQ-032 Pop and credit_i in the same cycle at count=2 -> count stays 2; credit_i at count=4 with no pop -> stays 4.
REQ-033 Assert rst in LOCKED with lock=w -> all outputs reset asynchronously, credit=4; after release a west body flit with req_w_i=1 is not popped.
